// File: rtl/wb_sdspi_stream_adapter.sv
// rtl/wb_sdspi_stream_adapter.sv - Wishbone front end with byte prefetch FIFO for SD-SPI sequential reads
// A BLOCK_ADDR write opens a multi-block session; the engine then keeps the FIFO topped up.
module wb_sdspi_stream_adapter #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        spi_rst,
  output logic        spi_r_multi_block,
  output logic        spi_r_byte,
  output logic [31:0] spi_block_addr,
  output logic [4:0]  spi_sclk_speed,
  input  logic        spi_busy,
  input  logic        spi_err,
  input  logic [7:0]  spi_dat_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   BPW_L   = (AW+1)'(BYTES_PER_WORD);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] BPW_P   = AW'(BYTES_PER_WORD);

  typedef enum logic [3:0] {
    ST_START, ST_IDLE, ST_OPEN_0, ST_OPEN_1, ST_OPEN_2, ST_OPEN_3,
    ST_FETCH, ST_GAP, ST_WAIT_BUSY, ST_PUSH
  } state_t;

  state_t        r_state, r_ret;
  logic          r_discard, r_session, r_err;
  logic          r_ack, r_err_o, r_spi_rst, r_multi, r_r_byte;
  logic [31:0]   r_dat, r_block_addr;
  logic [4:0]    r_sclk;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;

  logic        w_req, w_rd_data, w_data_bad, w_pop, w_push;
  logic        w_addr_wr, w_flush, w_err_clr;
  logic [31:0] w_pack, w_status;

  always_comb begin
    // The cycle right after a termination is masked so a held strobe is not served twice.
    w_req      = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err_o;
    w_rd_data  = w_req & ~wb_we_i & (wb_adr_i == 2'd1);
    w_data_bad = r_err | ~r_session;
    w_pop      = w_rd_data & ~w_data_bad & (r_level >= BPW_L);
    w_push     = (r_state == ST_PUSH) & ~r_err & r_session;
    w_addr_wr  = w_req & wb_we_i & (wb_adr_i == 2'd0) & (r_state == ST_IDLE);
    w_flush    = (r_state == ST_START) | w_addr_wr;
    w_err_clr  = (w_req & wb_we_i & (wb_adr_i == 2'd3) & wb_dat_i[1]) | w_addr_wr;
    w_status   = {16'b0, 8'(r_level), 5'b0, r_session, r_err, spi_busy};
    w_pack     = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++)
      w_pack[8*k +: 8] = r_mem[r_rd_ptr + AW'(k)];
  end

  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= spi_dat_o;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state <= ST_START;       r_ret <= ST_IDLE;
      r_discard <= 1'b0;         r_session <= 1'b0;    r_err <= 1'b0;
      r_ack <= 1'b0;             r_err_o <= 1'b0;      r_dat <= '0;
      r_spi_rst <= 1'b1;         r_multi <= 1'b0;      r_r_byte <= 1'b0;
      r_block_addr <= '0;        r_sclk <= '0;
      r_wr_ptr <= '0;            r_rd_ptr <= '0;       r_level <= '0;
    end else begin
      r_ack    <= 1'b0;
      r_err_o  <= 1'b0;
      r_r_byte <= 1'b0;

      if (w_req) begin
        case (wb_adr_i)
          2'd0: if (!wb_we_i) begin r_dat <= r_block_addr; r_ack <= 1'b1; end
          2'd1: begin
            if (wb_we_i)         r_ack <= 1'b1;
            else if (w_data_bad) r_err_o <= 1'b1;
            else if (w_pop)      begin r_dat <= w_pack; r_ack <= 1'b1; end
          end
          2'd2: begin
            if (wb_we_i) r_sclk <= wb_dat_i[4:0];
            else         r_dat <= {27'b0, r_sclk};
            r_ack <= 1'b1;
          end
          default: begin
            if (!wb_we_i) r_dat <= w_status;
            r_ack <= 1'b1;
          end
        endcase
      end

      if (w_err_clr) r_err <= 1'b0;
      if (spi_err)   r_err <= 1'b1;

      if (w_flush) begin
        r_wr_ptr <= '0; r_rd_ptr <= '0; r_level <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + BPW_P;
        r_level <= r_level + {{AW{1'b0}}, w_push} - (w_pop ? BPW_L : '0);
      end

      case (r_state)
        ST_START: begin
          r_spi_rst <= 1'b0; r_session <= 1'b0;
          r_state <= ST_WAIT_BUSY; r_ret <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_addr_wr) begin
            r_block_addr <= wb_dat_i; r_session <= 1'b0; r_state <= ST_OPEN_0;
          end else if (r_session && (r_level < DEPTH_L) && !r_err) begin
            r_r_byte <= 1'b1; r_discard <= 1'b0; r_state <= ST_FETCH;
          end
        end
        ST_OPEN_0: begin r_multi <= 1'b0; r_state <= ST_WAIT_BUSY; r_ret <= ST_OPEN_1; end
        ST_OPEN_1: begin r_multi <= 1'b1; r_state <= ST_WAIT_BUSY; r_ret <= ST_OPEN_2; end
        ST_OPEN_2: begin r_r_byte <= 1'b1; r_discard <= 1'b1; r_state <= ST_FETCH; end
        ST_OPEN_3: begin r_session <= 1'b1; r_ack <= 1'b1; r_state <= ST_IDLE; end
        ST_FETCH:  r_state <= ST_GAP;
        // GAP gives the core a cycle to raise busy before it is sampled.
        ST_GAP: begin
          r_state <= ST_WAIT_BUSY;
          r_ret   <= r_discard ? ST_OPEN_3 : ST_PUSH;
        end
        ST_WAIT_BUSY: if (!spi_busy) r_state <= r_ret;
        ST_PUSH:      r_state <= ST_IDLE;
        default:      r_state <= ST_START;
      endcase
    end
  end

  assign wb_dat_o          = r_dat;
  assign wb_ack_o          = r_ack;
  assign wb_err_o          = r_err_o;
  assign wb_rty_o          = 1'b0;
  assign spi_rst           = r_spi_rst;
  assign spi_r_multi_block = r_multi;
  assign spi_r_byte        = r_r_byte;
  assign spi_block_addr    = r_block_addr;
  assign spi_sclk_speed    = r_sclk;

endmodule

// File: tb/tb_wb_sdspi_stream_adapter.sv
// tb/tb_wb_sdspi_stream_adapter.sv - directed scoreboard bench for wb_sdspi_stream_adapter
// A small SD-SPI core model streams 0x11,0x22,... after one discarded byte per session.
module tb_wb_sdspi_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, cyc, stb, spi_err_i;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat, rdat1, baddr, baddr1;
  logic        ack, err, rty, ack1, err1, rty1;
  logic        srst, multi, rbyte, srst1, multi1, rbyte1;
  logic [4:0]  sclk, sclk1;
  logic        busy = 1'b0;
  logic [7:0]  sdat = 8'h00;

  wb_sdspi_stream_adapter u_dut (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .spi_rst(srst), .spi_r_multi_block(multi), .spi_r_byte(rbyte),
    .spi_block_addr(baddr), .spi_sclk_speed(sclk), .spi_busy(busy), .spi_err(spi_err_i),
    .spi_dat_o(sdat));

  wb_sdspi_stream_adapter #(.BYTES_PER_WORD(1)) u_dut1 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat1),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack1), .wb_err_o(err1),
    .wb_rty_o(rty1), .spi_rst(srst1), .spi_r_multi_block(multi1), .spi_r_byte(rbyte1),
    .spi_block_addr(baddr1), .spi_sclk_speed(sclk1), .spi_busy(busy), .spi_err(spi_err_i),
    .spi_dat_o(sdat));

  // Core model: every op keeps busy high for 3 cycles; byte reads deliver data at the end.
  logic [7:0] sb [$];
  logic       prev_multi = 1'b0, discard = 1'b0, pending = 1'b0;
  logic [7:0] byte_val = 8'h11;
  int         cnt = 0, n_disc = 0;

  always @(posedge clk) begin
    prev_multi <= multi;
    if (multi && !prev_multi) begin
      discard <= 1'b1; byte_val <= 8'h11; sb.delete();
    end
    if (rbyte || (multi != prev_multi)) begin
      cnt <= 3; busy <= 1'b1;
      if (rbyte) pending <= 1'b1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        busy <= 1'b0;
        if (pending) begin
          pending <= 1'b0;
          if (discard) begin
            sdat <= 8'hEE; discard <= 1'b0; n_disc <= n_disc + 1;
          end else begin
            sdat <= byte_val; sb.push_back(byte_val); byte_val <= byte_val + 8'h11;
          end
        end
      end
    end
  end

  int   rst_cnt = 0, rb_cnt = 0, ack_cnt = 0, rises = 0, falls = 0;
  logic mon_multi = 1'b0;
  always @(negedge clk) begin
    rst_cnt   <= rst_cnt + int'(srst);
    rb_cnt    <= rb_cnt + int'(rbyte);
    ack_cnt   <= ack_cnt + int'(ack);
    mon_multi <= multi;
    if (multi && !mon_multi) rises <= rises + 1;
    if (!multi && mon_multi) falls <= falls + 1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output logic ga, output logic ge, output int lat);
    adr = a; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
    lat = 0; ga = 1'b0; ge = 1'b0; rd = '0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack || err) begin ga = ack; ge = err; rd = rdat; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pop_word(input int bpw);
    logic [31:0] wv = '0;
    for (int k = 0; k < bpw; k++)
      if (sb.size() > 0) wv[8*k +: 8] = sb.pop_front();
    return wv;
  endfunction

  initial begin
    logic [31:0] rd, expw;
    logic        ga, ge, found;
    int          lat, snap, snap2, snap3;

    rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; spi_err_i = 1'b0;
    idle(3);
    check("rst_outs", {ack, err, rty, rbyte, multi}, 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_addr_sclk", {baddr[26:0], sclk}, 32'h0);
    check("dut1_rst", {31'b0, |{ack1, err1, rty1, rbyte1, multi1, baddr1, sclk1, rdat1}}, 32'h0);
    check("dut1_srst", {31'b0, srst1}, 32'h1);
    snap = rst_cnt;
    rst = 1'b0;
    idle(10);
    check("spi_rst_pulse", rst_cnt - snap, 32'd1);

    bus(2'd3, 1'b0, 32'h0, rd, ga, ge, lat);
    check("status_reset", rd, 32'h0);
    check("status_lat", lat, 32'd1);
    bus(2'd2, 1'b1, 32'hFFFF_FFF5, rd, ga, ge, lat);
    check("sclk_out", {27'b0, sclk}, 32'h15);
    bus(2'd2, 1'b0, 32'h0, rd, ga, ge, lat);
    check("sclk_read", rd, 32'h15);
    bus(2'd1, 1'b0, 32'h0, rd, ga, ge, lat);
    check("data_nosession_err", {30'b0, ga, ge}, 32'h1);
    bus(2'd1, 1'b1, 32'h1234, rd, ga, ge, lat);
    check("data_write_ack", {30'b0, ga, ge}, 32'h2);

    snap = rises; snap2 = n_disc;
    bus(2'd0, 1'b1, 32'h0000_0040, rd, ga, ge, lat);
    check("open_ack", {30'b0, ga, ge}, 32'h2);
    check("open_addr", baddr, 32'h40);
    check("open_multi_rise", rises - snap, 32'd1);
    check("open_discard", n_disc - snap2, 32'd1);

    idle(300);
    bus(2'd3, 1'b0, 32'h0, rd, ga, ge, lat);
    check("status_full", rd, 32'h0000_1004);
    snap = rb_cnt;
    idle(60);
    check("no_fetch_full", rb_cnt - snap, 32'd0);

    check("sb_avail", {31'b0, sb.size() >= 16}, 32'h1);
    expw = pop_word(4);
    bus(2'd1, 1'b0, 32'h0, rd, ga, ge, lat);
    check("data0", rd, expw);
    check("data0_lat", lat, 32'd1);
    check("bpw1_data", rdat1, {24'b0, expw[7:0]});
    snap = rb_cnt;
    idle(150);
    check("refetch4", rb_cnt - snap, 32'd4);

    expw = pop_word(4);
    bus(2'd1, 1'b0, 32'h0, rd, ga, ge, lat);
    check("data1", rd, expw);

    idle(3);
    spi_err_i = 1'b1;
    idle(1);
    spi_err_i = 1'b0;
    idle(100);
    bus(2'd3, 1'b0, 32'h0, rd, ga, ge, lat);
    check("err_status", rd & 32'h2, 32'h2);
    bus(2'd1, 1'b0, 32'h0, rd, ga, ge, lat);
    check("err_data", {30'b0, ga, ge}, 32'h1);
    snap = rb_cnt;
    idle(60);
    check("err_no_fetch", rb_cnt - snap, 32'd0);
    bus(2'd3, 1'b1, 32'h2, rd, ga, ge, lat);
    check("err_clear_ack", {31'b0, ga}, 32'h1);
    snap = rb_cnt;
    idle(100);
    check("fetch_resumed", {31'b0, (rb_cnt - snap) > 0}, 32'h1);
    bus(2'd3, 1'b0, 32'h0, rd, ga, ge, lat);
    check("err_cleared", rd & 32'h2, 32'h0);

    snap = rises; snap2 = falls; snap3 = n_disc;
    bus(2'd0, 1'b1, 32'h0000_0080, rd, ga, ge, lat);
    check("reopen_ack", {31'b0, ga}, 32'h1);
    check("reopen_addr", baddr, 32'h80);
    check("reopen_multi", {rises - snap, falls - snap2}, {32'd1, 32'd1});
    check("reopen_discard", n_disc - snap3, 32'd1);
    bus(2'd1, 1'b0, 32'h0, rd, ga, ge, lat);
    expw = pop_word(4);
    check("reopen_data", rd, expw);

    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rbyte) begin found = 1'b1; break; end
    end
    check("fetch_seen", {31'b0, found}, 32'h1);
    idle(2);
    snap = ack_cnt;
    adr = 2'd0; we = 1'b1; wdat = 32'hC0; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    idle(1);
    snap2 = rst_cnt;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(20);
    check("midrst_no_ack", ack_cnt - snap, 32'd0);
    check("midrst_spi_rst", rst_cnt - snap2, 32'd1);
    check("midrst_multi", {31'b0, multi}, 32'h0);
    bus(2'd3, 1'b0, 32'h0, rd, ga, ge, lat);
    check("midrst_status", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
